// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer,
// mid-bit sampling and a valid/ready output holding register.
module uart_rx #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    shift, shift_n;
   logic          sync1, line;
   logic          deliver, ferr;

   // Synchronizer resets high so reset never looks like a start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         line  <= 1'b1;
      end else begin
         sync1 <= rx;
         line  <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shift <= shift_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shift_n = shift;
      deliver = 1'b0;
      ferr    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!line) begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            if (cnt == HALF) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = line ? IDLE : DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == LAST) begin
               cnt_n        = '0;
               shift_n[idx] = line;
               if (idx == 3'd7) state_n = STOP;
               else idx_n = idx + 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == LAST) begin
               cnt_n = '0;
               if (line) begin
                  deliver = 1'b1;
                  state_n = IDLE;
               end else begin
                  ferr    = 1'b1;
                  state_n = WAIT_HIGH;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (line) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // A delivery always wins over a same-cycle consume
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr;
         overrun   <= deliver && rx_valid && !rx_ready;
         if (deliver) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random 8N1 frames against a frame-level
// reference model, outputs compared every clock.
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int LAT = 3 + CPB / 2 + 9 * CPB;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun, busy;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx(rx),
      .rx_ready(rx_ready),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .frame_err(frame_err),
      .overrun(overrun),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      bit         ferr;
      logic [7:0] d;
   } ev_t;

   ev_t evq[$];
   int  win_lo[$];
   int  win_hi[$];
   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  last_fall = 0;
   int  rdy_pulse = -1;
   bit  rdy_hold = 1'b0;
   bit  rdy_rand = 1'b0;

   logic       m_valid = 1'b0, m_ferr = 1'b0;
   logic       m_ovr = 1'b0, m_busy = 1'b0;
   logic [7:0] m_data = 8'h00;
   ev_t        cur;
   bit         deliv;

   int   ferr_cnt = 0, ovr_cnt = 0, vh_cnt = 0, rise_cyc = 0;
   logic prev_valid = 1'b0;

   function automatic void check(string name, logic [31:0] act,
                                 logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0d expected %0d",
                  name, cyc, act, exp);
      end
   endfunction

   // Model: frames scheduled by the driver become output events
   always begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         m_ferr  = 1'b0;
         m_ovr   = 1'b0;
         evq.delete();
         win_lo.delete();
         win_hi.delete();
      end else begin
         deliv  = 1'b0;
         m_ferr = 1'b0;
         m_ovr  = 1'b0;
         if (evq.size() > 0 && evq[0].cyc == cyc) begin
            cur = evq.pop_front();
            if (cur.ferr) m_ferr = 1'b1;
            else deliv = 1'b1;
         end
         if (deliv) begin
            m_ovr   = m_valid && !rx_ready;
            m_valid = 1'b1;
            m_data  = cur.d;
         end else if (m_valid && rx_ready) begin
            m_valid = 1'b0;
         end
      end
      m_busy = 1'b0;
      foreach (win_lo[i])
         if (cyc >= win_lo[i] && cyc <= win_hi[i]) m_busy = 1'b1;
      #1;
      check("rx_valid", 32'(rx_valid), 32'(m_valid));
      check("rx_data", 32'(rx_data), 32'(m_data));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("busy", 32'(busy), 32'(m_busy));
      ferr_cnt += int'(frame_err);
      ovr_cnt  += int'(overrun);
      vh_cnt   += int'(rx_valid);
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_valid;
   end

   always begin
      @(posedge clk);
      #2;
      rx_ready = rdy_hold || (rdy_rand && $urandom_range(0, 2) == 0)
                 || (cyc + 1 == rdy_pulse);
   end

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input bit g);
      for (int i = 0; i < CPB; i++) begin
         rx = (g && i == 1) ? ~b : b;
         @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit good,
                             input int low_len, input bit glitchy,
                             input bit rpulse);
      ev_t e;
      int  fall;
      fall      = cyc;
      last_fall = fall;
      e.cyc  = fall + LAT;
      e.ferr = !good;
      e.d    = d;
      evq.push_back(e);
      if (rpulse) rdy_pulse = fall + LAT;
      win_lo.push_back(fall + 3);
      win_hi.push_back(good ? fall + LAT - 1
                            : fall + 9 * CPB + low_len + 2);
      send_bit(1'b0, 1'b0);
      for (int k = 0; k < 8; k++)
         send_bit(d[k], glitchy && $urandom_range(0, 1) == 1);
      if (good) begin
         send_bit(1'b1, 1'b0);
      end else begin
         rx = 1'b0;
         repeat (low_len) @(negedge clk);
         rx = 1'b1;
      end
   endtask

   task automatic consume();
      rdy_hold = 1'b1;
      repeat (3) @(negedge clk);
      rdy_hold = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   int         f0, o0, v0;
   int         gfall;
   bit         good;
   logic [7:0] rd;

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset_valid", 32'(rx_valid), 32'd0);
      check("reset_data", 32'(rx_data), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(5);

      // 0xA5, nobody consuming
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
      idle(20);
      check("a5_data", 32'(rx_data), 32'hA5);
      check("a5_valid", 32'(rx_valid), 32'd1);
      check("a5_latency", 32'(rise_cyc - last_fall), 32'd155);
      check("a5_no_err", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);
      consume();
      check("a5_consumed", 32'(rx_valid), 32'd0);

      // 4-clock low glitch on an idle line
      f0 = ferr_cnt;
      gfall = cyc;
      win_lo.push_back(gfall + 3);
      win_hi.push_back(gfall + 10);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      idle(20);
      check("glitch_valid", 32'(rx_valid), 32'd0);
      check("glitch_err", 32'(ferr_cnt - f0), 32'd0);

      // Stop bit held low 40 clocks, then a good frame
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, 40, 1'b0, 1'b0);
      idle(10);
      send_frame(8'h81, 1'b1, 0, 1'b0, 1'b0);
      idle(10);
      check("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
      check("after_ferr_data", 32'(rx_data), 32'h81);
      check("after_ferr_valid", 32'(rx_valid), 32'd1);
      consume();

      // Back-to-back frames with no consumer
      o0 = ovr_cnt;
      send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b1, 0, 1'b0, 1'b0);
      idle(10);
      check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
      check("ovr_data", 32'(rx_data), 32'hC3);
      consume();

      // Consumer always ready
      rdy_hold = 1'b1;
      idle(3);
      o0 = ovr_cnt;
      v0 = vh_cnt;
      send_frame(8'h11, 1'b1, 0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 0, 1'b0, 1'b0);
      idle(10);
      check("ready_valid_cycles", 32'(vh_cnt - v0), 32'd2);
      check("ready_no_ovr", 32'(ovr_cnt - o0), 32'd0);
      rdy_hold = 1'b0;
      idle(3);

      // Ready only in the delivery cycle of the second byte
      o0 = ovr_cnt;
      send_frame(8'h11, 1'b1, 0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 0, 1'b0, 1'b1);
      idle(10);
      check("same_cycle_no_ovr", 32'(ovr_cnt - o0), 32'd0);
      check("same_cycle_data", 32'(rx_data), 32'h22);
      check("same_cycle_valid", 32'(rx_valid), 32'd1);

      // Reset in the middle of data bit 4 of 0xFF
      fork
         send_frame(8'hFF, 1'b1, 0, 1'b0, 1'b0);
         begin
            repeat (CPB * 5 + 8) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("midrst_valid", 32'(rx_valid), 32'd0);
            check("midrst_data", 32'(rx_data), 32'd0);
            check("midrst_busy", 32'(busy), 32'd0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
         end
      join
      idle(5);
      send_frame(8'h55, 1'b1, 0, 1'b0, 1'b0);
      idle(10);
      check("post_rst_data", 32'(rx_data), 32'h55);
      check("post_rst_valid", 32'(rx_valid), 32'd1);
      consume();

      // Random frames, glitches, stop errors and consumer
      rdy_rand = 1'b1;
      for (int f = 0; f < 40; f++) begin
         rd   = 8'($urandom);
         good = $urandom_range(0, 4) != 0;
         send_frame(rd, good, CPB + $urandom_range(0, 30), 1'b1, 1'b0);
         idle((good ? 0 : 4) + $urandom_range(0, 10));
      end
      idle(20);
      rdy_rand = 1'b0;
      idle(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have a parameter CLKS_PER_BIT, default 10416 (100 MHz / 9600 baud), giving clock cycles per bit period; legal range 4..65535.
REQ-002 The block SHALL have the port clk, input, 1 bit: single rising-edge clock for all logic.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have the port rx, input, 1 bit: serial line; asynchronous to clk; idle high.
REQ-005 The block SHALL have the port rx_ready, input, 1 bit: consumer accepts rx_data when high with rx_valid.
REQ-006 The block SHALL have the port rx_data, output, 8 bits: last received byte.
REQ-007 The block SHALL have the port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-008 The block SHALL have the port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples 0.
REQ-009 The block SHALL have the port overrun, output, 1 bit: one-cycle pulse when a byte is delivered over an unconsumed byte.
REQ-010 The block SHALL have the port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; all references to "line" below mean the synchronized value.
REQ-012 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); no parity.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH, and a bit counter of width ceil(log2(CLKS_PER_BIT)).
REQ-014 IDLE: line==0 -> START, counter cleared.
REQ-015 START: at counter == CLKS_PER_BIT/2 - 1 (integer division), the line SHALL be sampled. If 0 -> DATA with counter and bit index cleared; if 1 -> IDLE as a glitch, with no output activity.
REQ-016 DATA: at counter == CLKS_PER_BIT-1, the line SHALL be sampled into shift bit[index] and the counter cleared. After index 7 -> STOP; otherwise the index increments.
REQ-017 STOP: at counter == CLKS_PER_BIT-1, the line SHALL be sampled. If 1 -> deliver byte (REQ-019), then IDLE. If 0 -> frame_err pulse, no delivery, then WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until line==1, then IDLE; a break condition SHALL NOT generate false start bits.
REQ-019 Delivery SHALL take one cycle: rx_data loads the shift register and rx_valid is set.
REQ-020 Consume: rx_valid && rx_ready in a cycle with no delivery SHALL clear rx_valid next cycle; rx_data holds its value.
REQ-021 Delivery while rx_valid=1 and rx_ready=0 SHALL overwrite rx_data, keep rx_valid=1, and pulse overrun.
REQ-022 Delivery in the same cycle as rx_valid && rx_ready SHALL NOT pulse overrun; rx_valid stays 1 with the new data.
REQ-023 Latency: rx_valid SHALL rise 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks (±2) after the rx pin falls at the start edge.
REQ-024 The FSM SHALL ignore the line outside its sample points; mid-bit glitches after START validation SHALL NOT affect state.
REQ-025 frame_err and overrun SHALL each be high for exactly one clock per event.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, counters 0, shift register 0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame without delivering partial data.
REQ-028 After rst_n deasserts, the first line==0 SHALL be treated as a start edge.

Verification (CLKS_PER_BIT=16)
REQ-029 Send 0xA5 8N1, rx_ready=0 -> rx_data=0xA5, rx_valid=1 at about 155 clocks, frame_err=0, overrun=0.
REQ-030 rx low 4 clocks then high -> busy pulses, returns IDLE, rx_valid stays 0, and no error pulse.
REQ-031 Send 0x3C with stop bit 0 held low 40 clocks, then 0x81 -> one frame_err pulse, no delivery for 0x3C, FSM in WAIT_HIGH until line high, then rx_data=0x81.
REQ-032 Send 0x3C then 0xC3 back-to-back, rx_ready=0 -> rx_data=0xC3, rx_valid=1, one overrun pulse at the second delivery.
REQ-033 rx_ready=1 held while sending 0x11, 0x22 -> each rx_valid high exactly 1 cycle, no overrun; rx_ready asserted exactly in the delivery cycle of 0x22 with 0x11 still pending -> no overrun.
REQ-034 rst_n pulse low at data bit 4 of 0xFF -> all outputs at reset values; after release, send 0x55 -> rx_data=0x55, rx_valid=1.
